// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with flush/stall, halt-on-stop and saturating perf counters.
module mem_wb_stage #(
    parameter logic [7:0] NOP_IR = 8'h0A,
    parameter int         CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       ir3,
    input  logic             en_mem,
    input  logic [7:0]       alu_out3,
    input  logic [7:0]       mem_rdata,
    input  logic             stall,
    input  logic             flush,
    input  logic             stop_wb,
    output logic [7:0]       ir4,
    output logic             en_wb,
    output logic [7:0]       aluout4,
    output logic [7:0]       mdr4,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    logic cyc_inc, ins_inc;
    always_comb begin
        cyc_inc = ~&cycle_count;
        ins_inc = en_wb & ~stop_wb & ~&instr_count;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ir4         <= NOP_IR;
            en_wb       <= 1'b0;
            aluout4     <= 8'h00;
            mdr4        <= 8'h00;
            halted      <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else if (halted) begin
            en_wb <= 1'b0;
        end else begin
            halted      <= en_wb & stop_wb;
            cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, cyc_inc};
            instr_count <= instr_count + {{(CNT_W-1){1'b0}}, ins_inc};
            if (flush) begin
                ir4   <= NOP_IR;
                en_wb <= 1'b0;
            end else if (stall) begin
                en_wb <= 1'b0;
            end else begin
                ir4     <= ir3;
                aluout4 <= alu_out3;
                mdr4    <= mem_rdata;
                en_wb   <= en_mem;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: random and directed checks of mem_wb_stage against a behavioural model.
module tb_mem_wb_stage;
    localparam int MAXC = 65535;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] ir3 = 8'h00, alu_out3 = 8'h00, mem_rdata = 8'h00;
    logic en_mem = 1'b0, stall = 1'b0, flush = 1'b0, stop_wb = 1'b0;
    logic [7:0] ir4, aluout4, mdr4;
    logic en_wb, halted;
    logic [15:0] cycle_count, instr_count;
    int checks = 0, passed = 0;
    int m_ir, m_alu, m_mdr, m_en, m_halt, m_cyc, m_ins;
    int ins_frozen;

    mem_wb_stage dut (
        .clock(clock), .reset(reset), .ir3(ir3), .en_mem(en_mem), .alu_out3(alu_out3),
        .mem_rdata(mem_rdata), .stall(stall), .flush(flush), .stop_wb(stop_wb),
        .ir4(ir4), .en_wb(en_wb), .aluout4(aluout4), .mdr4(mdr4), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        int nh;
        @(posedge clock);
        if (reset) begin
            m_ir = 'h0A; m_en = 0; m_alu = 0; m_mdr = 0; m_halt = 0; m_cyc = 0; m_ins = 0;
        end else if (m_halt == 1) begin
            m_en = 0;
        end else begin
            nh = (m_en == 1 && stop_wb) ? 1 : 0;
            m_cyc = (m_cyc + 1 > MAXC) ? MAXC : m_cyc + 1;
            if (m_en == 1 && !stop_wb) m_ins = (m_ins + 1 > MAXC) ? MAXC : m_ins + 1;
            if (flush) begin
                m_ir = 'h0A; m_en = 0;
            end else if (stall) begin
                m_en = 0;
            end else begin
                m_ir = ir3; m_alu = alu_out3; m_mdr = mem_rdata; m_en = en_mem;
            end
            m_halt = nh;
        end
        #1;
        chk("ir4", ir4, m_ir);
        chk("en_wb", en_wb, m_en);
        chk("aluout4", aluout4, m_alu);
        chk("mdr4", mdr4, m_mdr);
        chk("halted", halted, m_halt);
        chk("cycle_count", cycle_count, m_cyc);
        chk("instr_count", instr_count, m_ins);
    endtask

    task automatic drive(input logic [7:0] i, input logic [7:0] a, input logic [7:0] m,
                         input logic e, input logic st, input logic fl, input logic sp);
        reset = 1'b0; ir3 = i; alu_out3 = a; mem_rdata = m;
        en_mem = e; stall = st; flush = fl; stop_wb = sp;
    endtask

    initial begin
        tick();
        chk("rst_ir4", ir4, 'h0A);
        chk("rst_cyc", cycle_count, 0);
        // randomized traffic, occasional reset and stop
        for (int n = 0; n < 400; n++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 25) == 0);
            reset = $urandom_range(0, 40) == 0;
            tick();
        end
        reset = 1'b1; tick();
        drive(8'h14, 8'h3C, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("adv_ir4", ir4, 'h14);
        chk("adv_alu", aluout4, 'h3C);
        chk("adv_mdr", mdr4, 'h55);
        chk("adv_en", en_wb, 1);
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("adv_ins", instr_count, 1);
        drive(8'h20, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(8'h33, 8'h99, 8'h88, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        chk("fl_ir4", ir4, 'h0A);
        chk("fl_en", en_wb, 0);
        chk("fl_alu", aluout4, 'h11);
        chk("fl_mdr", mdr4, 'h22);
        drive(8'h44, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(8'h55, 8'h03, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        chk("st_ir4", ir4, 'h44);
        chk("st_en", en_wb, 0);
        reset = 1'b1; tick();
        for (int n = 0; n < 9; n++) begin
            drive(8'h14, 8'(n), 8'(n), 1'b1, 1'b0, 1'b0, 1'b0); tick();
        end
        drive(8'h14, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        chk("halt_set", halted, 1);
        chk("halt_cyc", cycle_count, 10);
        chk("halt_ins", instr_count, 8);
        ins_frozen = instr_count;
        for (int n = 0; n < 20; n++) begin
            drive(8'h66, 8'h77, 8'h88, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom)); tick();
            chk("halt_en", en_wb, 0);
        end
        chk("halt_cyc_hold", cycle_count, 10);
        chk("halt_ins_hold", instr_count, ins_frozen);
        chk("halt_ir_hold", ir4, 'h14);
        reset = 1'b1; tick();
        chk("rh_halt", halted, 0);
        chk("rh_cyc", cycle_count, 0);
        chk("rh_ins", instr_count, 0);
        chk("rh_ir4", ir4, 'h0A);
        chk("rh_alu", aluout4, 0);
        drive(8'h71, 8'h72, 8'h73, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("rh_resume", ir4, 'h71);
        chk("rh_resume_en", en_wb, 1);
        reset = 1'b1; tick();
        for (int n = 0; n < 65540; n++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0); tick();
        end
        chk("sat_cyc", cycle_count, 'hFFFF);
        chk("sat_ins", instr_count, 'hFFFF);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
